// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and the request error check for the RMW LSU.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Size code 3 is illegal, sub-word accesses must be naturally aligned,
    // and the word index must fall inside the attached memory.
    function automatic logic access_err(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input logic [29:0] words);
        return (size == 2'd3)
            || (size == SZ_H && addr[0])
            || (size == SZ_W && addr[1:0] != 2'b00)
            || (addr[31:2] >= words);
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Little-endian lane extract/extend for loads and lane merge
//               for stores. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_load,
    output logic [31:0] o_store
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_bsign;
    logic        w_hsign;

    assign w_byte  = i_word[{i_lane, 3'b000} +: 8];
    assign w_half  = i_word[{i_lane[1], 4'b0000} +: 16];
    assign w_bsign = ~i_unsigned & w_byte[7];
    assign w_hsign = ~i_unsigned & w_half[15];

    always_comb begin
        o_load = i_word;
        case (i_size)
            SZ_B:    o_load = {{24{w_bsign}}, w_byte};
            SZ_H:    o_load = {{16{w_hsign}}, w_half};
            default: o_load = i_word;
        endcase
    end

    // Only the addressed lane is replaced; upper wdata bits are ignored.
    always_comb begin
        o_store = i_word;
        case (i_size)
            SZ_B:    o_store[{i_lane, 3'b000} +: 8]     = i_wdata[7:0];
            SZ_H:    o_store[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_store = i_wdata;
        endcase
    end

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu_rmw.sv
`default_nettype none
// ============================================================================
// Module      : lsu_rmw
// Description : Byte/half/word load-store unit with read-modify-write for
//               sub-word stores against a word-only memory.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [29:0] c_mem_words = 30'(MEM_WORDS);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_buf;

    logic        w_err;
    logic        w_accept;
    logic [31:0] w_aligned;
    logic [31:0] w_align_word;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_err        = access_err(req_size, req_addr, c_mem_words);
    assign w_accept     = (r_state == IDLE) && req_valid;
    assign w_aligned    = {r_addr[31:2], 2'b00};
    assign w_align_word = (r_state == RMW_WR) ? r_buf : mem_rd;

    lsu_align u_align (
        .i_word     (w_align_word),
        .i_wdata    (r_wdata),
        .i_lane     (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_load     (w_load),
        .o_store    (w_merged)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory-facing outputs are decoded from state so reset drops them at once.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        mem_we      = 1'b0;
        mem_a       = 32'd0;
        mem_wd      = 32'd0;
        resp_valid  = 1'b0;
        resp_rdata  = 32'd0;
        resp_err    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_err)
                        w_state_nxt = RESP;
                    else if (!req_we || req_size == SZ_W)
                        w_state_nxt = ACCESS;
                    else
                        w_state_nxt = RMW_RD;
                end
            end
            ACCESS: begin
                mem_a = w_aligned;
                if (r_we) begin
                    mem_we = 1'b1;
                    mem_wd = r_wdata;
                end
                w_state_nxt = RESP;
            end
            RMW_RD: begin
                mem_a       = w_aligned;
                w_state_nxt = RMW_WR;
            end
            RMW_WR: begin
                mem_a       = w_aligned;
                mem_we      = 1'b1;
                mem_wd      = w_merged;
                w_state_nxt = RESP;
            end
            RESP: begin
                resp_valid  = 1'b1;
                resp_rdata  = (r_we || r_err) ? 32'd0 : r_rdata;
                resp_err    = r_err;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_err      <= 1'b0;
            r_rdata    <= 32'd0;
            r_buf      <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_err      <= w_err;
                r_rdata    <= 32'd0;
            end
            if (r_state == ACCESS && !r_we)
                r_rdata <= w_load;
            if (r_state == RMW_RD)
                r_buf <= mem_rd;
        end
    end

endmodule : lsu_rmw
`default_nettype wire

// File: tb/tb_lsu_rmw.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_rmw
// Description : Scoreboard bench for lsu_rmw with a behavioural word memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    lsu_rmw #(.MEM_WORDS(256)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_we       (mem_we),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    // Word memory: combinational read, synchronous write, plus a bench preload port.
    logic [31:0] mem [0:255];
    logic        bk_we = 1'b0;
    logic [7:0]  bk_idx = 8'd0;
    logic [31:0] bk_data = 32'd0;

    always @(posedge clk) begin
        if (mem_we && mem_a[31:10] == 22'd0)
            mem[mem_a[9:2]] <= mem_wd;
        else if (bk_we)
            mem[bk_idx] <= bk_data;
    end
    assign mem_rd = (mem_a[31:10] == 22'd0) ? mem[mem_a[9:2]] : 32'd0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we_off;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   we_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   prev_acc = 0;
    int   last_acc = 0;
    exp_t e;
    int   a;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset_n && req_valid && req_ready) begin
            acc_q.push_back(cyc);
            prev_acc = last_acc;
            last_acc = cyc;
        end
        cyc = cyc + 1;
    end

    // Response monitor
    always @(negedge clk) begin
        if (mem_we) we_q.push_back(cyc);
        if (resp_valid) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                chk("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
                chk("resp_err", 64'(resp_err), 64'(e.err));
                chk("resp_latency", 64'(cyc - a), 64'(e.lat));
                if (e.we_off >= 0) begin
                    chk("mem_we_pulses", 64'(we_q.size()), 64'd1);
                    if (we_q.size() == 1)
                        chk("mem_we_cycle", 64'(we_q[0] - a), 64'(e.we_off));
                end else begin
                    chk("mem_we_pulses", 64'(we_q.size()), 64'd0);
                end
                we_q.delete();
                chk("resp_ready", 64'(req_ready), 64'd0);
                chk("resp_mem_a", 64'(mem_a), 64'd0);
                chk("resp_mem_wd", 64'(mem_wd), 64'd0);
            end
        end
    end

    task automatic preload(input logic [7:0] idx, input logic [31:0] d);
        @(negedge clk);
        bk_we = 1'b1; bk_idx = idx; bk_data = d;
        @(negedge clk);
        bk_we = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] ad, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input int lat,
                         input int weoff, input bit keep, input bit want_resp);
        exp_t x;
        int   n;
        x.rdata = er; x.err = ee; x.lat = lat; x.we_off = weoff;
        if (want_resp) exp_q.push_back(x);
        req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = ad; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("accept_timeout", 64'd1, 64'd0);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (!keep) begin
            req_valid = 1'b0;
            req_we = ~we; req_size = 2'd3; req_unsigned = ~uns;
            req_addr = 32'hFFFF_FFFC; req_wdata = 32'hFFFF_FFFF;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_a", 64'(mem_a), 64'd0);
        chk("rst_mem_wd", 64'(mem_wd), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        preload(8'h04, 32'h80FF_7F01);
        preload(8'h08, 32'h1122_3344);
        preload(8'h0C, 32'h0000_0000);

        // Loads: we, size, uns, addr, wdata, rdata, err, lat, we_off
        issue(0, 2'd0, 0, 32'h11, 0, 32'h0000_007F, 0, 2, -1, 0, 1); drain();
        issue(0, 2'd0, 0, 32'h12, 0, 32'hFFFF_FFFF, 0, 2, -1, 0, 1); drain();
        issue(0, 2'd0, 1, 32'h12, 0, 32'h0000_00FF, 0, 2, -1, 0, 1); drain();
        issue(0, 2'd1, 0, 32'h12, 0, 32'hFFFF_80FF, 0, 2, -1, 0, 1); drain();
        issue(0, 2'd1, 1, 32'h12, 0, 32'h0000_80FF, 0, 2, -1, 0, 1); drain();
        issue(0, 2'd2, 0, 32'h10, 0, 32'h80FF_7F01, 0, 2, -1, 0, 1); drain();

        // Sub-word stores
        issue(1, 2'd0, 0, 32'h21, 32'h0000_00AB, 0, 0, 3, 2, 0, 1); drain();
        chk("sb_word", 64'(mem[8]), 64'h1122_AB44);
        issue(1, 2'd1, 0, 32'h22, 32'h0000_BEEF, 0, 0, 3, 2, 0, 1); drain();
        chk("sh_word", 64'(mem[8]), 64'hBEEF_AB44);

        // Word store and read-back
        issue(1, 2'd2, 0, 32'h30, 32'hDEAD_BEEF, 0, 0, 2, 1, 0, 1); drain();
        chk("sw_word", 64'(mem[12]), 64'hDEAD_BEEF);
        issue(0, 2'd2, 0, 32'h30, 0, 32'hDEAD_BEEF, 0, 2, -1, 0, 1); drain();

        // Errors
        issue(0, 2'd2, 0, 32'h12, 0, 0, 1, 1, -1, 0, 1); drain();
        issue(0, 2'd1, 0, 32'h13, 0, 0, 1, 1, -1, 0, 1); drain();
        issue(1, 2'd3, 0, 32'h21, 32'h0000_0055, 0, 1, 1, -1, 0, 1); drain();
        issue(1, 2'd2, 0, 32'h400, 32'h1234_5678, 0, 1, 1, -1, 0, 1); drain();
        chk("err_word8", 64'(mem[8]), 64'hBEEF_AB44);
        chk("err_word4", 64'(mem[4]), 64'h80FF_7F01);

        // Back-to-back with valid held; second request presented during ACCESS
        issue(0, 2'd2, 0, 32'h10, 0, 32'h80FF_7F01, 0, 2, -1, 1, 1);
        chk("access_ready", 64'(req_ready), 64'd0);
        issue(0, 2'd0, 1, 32'h12, 0, 32'h0000_00FF, 0, 2, -1, 0, 1);
        chk("b2b_spacing", 64'(last_acc - prev_acc), 64'd3);
        drain();

        // Reset during RMW_RD
        preload(8'h08, 32'h1122_3344);
        issue(1, 2'd0, 0, 32'h21, 32'h0000_00AB, 0, 0, 3, 2, 0, 0);
        reset_n = 1'b0;
        #1;
        chk("abort_resp_valid", 64'(resp_valid), 64'd0);
        chk("abort_resp_rdata", 64'(resp_rdata), 64'd0);
        chk("abort_resp_err", 64'(resp_err), 64'd0);
        chk("abort_mem_we", 64'(mem_we), 64'd0);
        chk("abort_mem_a", 64'(mem_a), 64'd0);
        chk("abort_mem_wd", 64'(mem_wd), 64'd0);
        repeat (2) @(negedge clk);
        chk("abort_we_pulses", 64'(we_q.size()), 64'd0);
        acc_q.delete();
        we_q.delete();
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_ready", 64'(req_ready), 64'd1);
        chk("abort_word", 64'(mem[8]), 64'h1122_3344);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_lsu_rmw
`default_nettype wire

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Initiator-side load/store unit between the multicycle CPU datapath and the word-addressed unified memory.
- The memory has a combinational read and a synchronous write. It only understands full 32-bit words (we, a, wd, rd).
- This block accepts byte, halfword and word loads/stores over a valid/ready request port. It performs read-modify-write for sub-word stores, and it sign- or zero-extends sub-word loads.
- It returns a single-cycle response with an error flag for misaligned or out-of-range accesses.

Parameters:
MEM_WORDS, 256, number of 32-bit words in the attached memory; word index addr[31:2] >= MEM_WORDS is out of range.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset_n  in  1  reset; asynchronous and active-low.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request (1 only in IDLE).
req_we  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
resp_valid  out  1  one-cycle pulse: request complete.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  request rejected, with no memory side effect.
mem_we  out  1  memory write enable.
mem_a  out  32  memory byte address, always word-aligned ({addr[31:2],2'b00}).
mem_wd  out  32  memory write data.
mem_rd  in  32  memory read data, combinational from mem_a in the same cycle.

Behaviour:
- Reset (async, while reset_n = 0): state = IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_we = 0, mem_a = 0, mem_wd = 0, internal latches = 0.
- Handshake:
  - Accept when req_valid && req_ready on a posedge.
  - On accept, latch we, size, unsigned, addr and wdata. Inputs are ignored outside IDLE.
  - No response backpressure; resp_valid is high for exactly one cycle.
- Error check at accept, combinational on the request fields. err = size==3 || (size==1 && addr[0]) || (size==2 && addr[1:0]!=0) || addr[31:2] >= MEM_WORDS.
- States:
  - IDLE: req_ready = 1, mem_we = 0.
    - On accept with err: go to RESP with err latched.
    - Load or word store: go to ACCESS.
    - Byte/half store: go to RMW_RD.
  - ACCESS: mem_a = aligned addr.
    - Word store: mem_we = 1, mem_wd = wdata.
    - Load: register the extracted and extended mem_rd lane into rdata.
    - Go to RESP.
  - RMW_RD: mem_a = aligned addr, mem_we = 0; register mem_rd into a word buffer. Go to RMW_WR.
  - RMW_WR: mem_a = aligned addr, mem_we = 1, mem_wd = buffer with the target lane replaced by wdata. Go to RESP.
  - RESP: resp_valid = 1; resp_rdata = rdata for a successful load, else 0; resp_err = latched err. Go to IDLE.
- Lane rules (little-endian):
  - Byte lane = addr[1:0]; byte k occupies bits [8k+7:8k].
  - Half lane = addr[1]; half h occupies bits [16h+15:16h].
  - Sign-extension uses the MSB of the extracted lane.
- Latency from the accept edge at cycle N:
  - Load or word store: resp_valid in cycle N+2.
  - Byte/half store: resp_valid in cycle N+3.
  - Error: resp_valid in cycle N+1.
- Accept-to-accept: next req_ready is in the cycle after RESP.
- mem_we is asserted for exactly one cycle per successful store and never for loads or errors.
- mem_a and mem_wd are 0 in IDLE and RESP.
- Reset mid-operation:
  - Reset asserted in RMW_RD aborts before any write; memory is unchanged.
  - Reset asserted in RMW_WR or ACCESS drops mem_we immediately (async). The write lands only if a posedge occurred with mem_we = 1 before reset.
  - No response is issued for an aborted request.

Decomposition:
- Package lsu_pkg holds:
  - size_t enum: SZ_B = 0, SZ_H = 1, SZ_W = 2.
  - state_t enum: IDLE, ACCESS, RMW_RD, RMW_WR, RESP.
- Sub-module lsu_align (combinational), used by lsu_rmw:
  - extract(word, addr[1:0], size, unsigned) → 32-bit extended load value.
  - merge(word, wdata, addr[1:0], size) → 32-bit store word.

Test Plan:
- Load extension: memory word 0x10 = 0x80FF7F01.
  - lb 0x11 → 0x0000007F.
  - lb 0x12 → 0xFFFFFFFF.
  - lbu 0x12 → 0x000000FF.
  - lh 0x12 → 0xFFFF80FF.
  - lhu 0x12 → 0x000080FF.
  - lw 0x10 → 0x80FF7F01.
  - Each load: resp_valid at N+2, resp_err = 0, mem_we never 1.
- Sub-word store: memory word 0x20 = 0x11223344.
  - sb 0x21 with wdata 0x000000AB → word becomes 0x1122AB44; mem_we high exactly in cycle N+2; resp_valid at N+3.
  - Then sh 0x22 with wdata 0xBEEF → word becomes 0xBEEFAB44.
- Word store: sw 0x30 with wdata 0xDEADBEEF → word 0x30 = 0xDEADBEEF, mem_we high one cycle at N+1, resp_valid at N+2; a following lw 0x30 returns 0xDEADBEEF.
- Errors:
  - Inputs: lw 0x12, lh 0x13, sb with size 3, sw 0x400 (word 256 with MEM_WORDS = 256).
  - Required response: resp_valid at N+1, resp_err = 1, resp_rdata = 0, mem_we stays 0, memory unchanged.
- Back-to-back and handshake:
  - Hold req_valid high with two loads queued: second accept occurs 3 cycles after the first.
  - req_ready = 0 throughout ACCESS and RESP; changing the request fields mid-operation does not alter the result.
- Reset mid-RMW:
  - Stimulus: sb 0x21 with wdata 0xAB to word 0x20 = 0x11223344; pull reset_n low during RMW_RD.
  - Required response: word stays 0x11223344, no resp_valid, all outputs at reset values, and req_ready = 1 after reset_n releases.
